// File: rtl/snake_pkg.sv
// Shared direction encoding for the snake game core (input front-end, main, board/body logic).
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package snake_pkg;

  // UP/DOWN and LEFT/RIGHT differ only in bit 1, so opposite() is a single XOR.
  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_LEFT  = 2'd1,
    DIR_DOWN  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_t;

  function automatic dir_t opposite(input dir_t x);
    return dir_t'(x ^ 2'b10);
  endfunction

endpackage

// File: rtl/dir_fifo.sv
// Synchronous FIFO of pending turn directions, DEPTH entries of dir_t.
// Latency: a push is visible in head/tail/count one edge later; all outputs come from registers.
// Backpressure: a push while full is only accepted when a pop happens on the same edge; otherwise ignored.
module dir_fifo
  import snake_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_push,
  input  dir_t          i_push_dat,
  input  logic          i_pop,
  output dir_t          o_head,
  output dir_t          o_tail,
  output logic [CW-1:0] o_count
);

  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  dir_t          r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  logic w_do_push;
  logic w_do_pop;

  // When full, the slot being popped this edge is the one written, so push-with-pop is safe.
  assign w_do_pop  = i_pop && (r_count != '0);
  assign w_do_push = i_push && ((r_count != FULL_CNT) || w_do_pop);

  // Storage write; contents need no reset since count qualifies every read.
  always_ff @(posedge i_clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_push_dat;
    end
  end

  // Pointers and occupancy.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_tail  = r_mem[r_wr_ptr - AW'(1)];
  assign o_count = r_count;

endmodule

// File: rtl/direction_controller.sv
// Key front-end: w/a/s/d press detection, turn legality check, turn queue, game-step tick.
// Latency: press pushed at the first edge seeing the rising key; queued turn reaches dir on the next tick edge.
// Backpressure: none upstream (keys cannot stall); full queue or reversal rejects the press with a dropped pulse.
module direction_controller
  import snake_pkg::*;
#(
  parameter int   DEPTH    = 4,
  parameter int   TICK_DIV = 8,
  parameter dir_t INIT_DIR = DIR_RIGHT,
  localparam int  PW       = $clog2(DEPTH + 1),
  localparam int  CNTW     = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_w,
  input  logic          i_a,
  input  logic          i_s,
  input  logic          i_d,
  input  logic          i_enable,
  output logic          o_tick,
  output dir_t          o_dir,
  output logic [PW-1:0] o_pending,
  output logic          o_dropped
);

  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(TICK_DIV - 1);
  localparam logic [PW-1:0]   FULL_CNT = PW'(DEPTH);

  logic [3:0]      r_key_q;
  logic [CNTW-1:0] r_cnt;
  logic            r_tick;
  dir_t            r_dir;
  logic            r_dropped;

  logic [3:0]    w_keys;
  logic [3:0]    w_press;
  logic          w_cand_vld;
  dir_t          w_cand;
  dir_t          w_ref;
  dir_t          w_head;
  dir_t          w_tail;
  logic [PW-1:0] w_count;
  logic          w_wrap;
  logic          w_pop;
  logic          w_full;
  logic          w_same;
  logic          w_opp;
  logic          w_push;
  logic          w_drop;

  // Bit order w,a,s,d from MSB; press is a rising level per key.
  assign w_keys  = {i_w, i_a, i_s, i_d};
  assign w_press = w_keys & ~r_key_q;

  // Pick a single candidate by priority w > a > s > d; the rest are discarded silently.
  always_comb begin
    w_cand_vld = 1'b1;
    w_cand     = DIR_UP;
    if (w_press[3])      w_cand = DIR_UP;
    else if (w_press[2]) w_cand = DIR_LEFT;
    else if (w_press[1]) w_cand = DIR_DOWN;
    else if (w_press[0]) w_cand = DIR_RIGHT;
    else                 w_cand_vld = 1'b0;
  end

  // Legality is judged against the last queued turn, or the live direction when nothing is queued.
  assign w_ref  = (w_count != '0) ? w_tail : r_dir;
  assign w_same = (w_cand == w_ref);
  assign w_opp  = (w_cand == opposite(w_ref));
  assign w_full = (w_count == FULL_CNT);

  assign w_wrap = i_enable && (r_cnt == CNT_LAST);
  assign w_pop  = w_wrap && (w_count != '0);

  assign w_push = w_cand_vld && !w_same && !w_opp && (!w_full || w_pop);
  assign w_drop = w_cand_vld && !w_same && (w_opp || (w_full && !w_pop));

  dir_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_push     (w_push),
    .i_push_dat (w_cand),
    .i_pop      (w_pop),
    .o_head     (w_head),
    .o_tail     (w_tail),
    .o_count    (w_count)
  );

  // Key history, step counter, tick strobe, live direction and drop pulse.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      // All-ones history means a key held through reset must be re-pressed.
      r_key_q   <= 4'b1111;
      r_cnt     <= '0;
      r_tick    <= 1'b0;
      r_dir     <= INIT_DIR;
      r_dropped <= 1'b0;
    end else begin
      r_key_q   <= w_keys;
      r_tick    <= w_wrap;
      r_dropped <= w_drop;
      if (!i_enable || w_wrap) r_cnt <= '0;
      else                     r_cnt <= r_cnt + CNTW'(1);
      if (w_pop) r_dir <= w_head;
    end
  end

  assign o_tick    = r_tick;
  assign o_dir     = r_dir;
  assign o_pending = w_count;
  assign o_dropped = r_dropped;

endmodule

// File: tb/tb_direction_controller.sv
// Directed bench for direction_controller with DEPTH=4, TICK_DIV=4, INIT_DIR=RIGHT.
// Latency: inputs driven 1 time unit after each rising edge, outputs sampled at the same point.
// Backpressure: n/a.
module tb_direction_controller;
  import snake_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       w, a, s, d, en;
  logic       tick;
  dir_t       dir;
  logic [2:0] pend;
  logic       drop;

  int n_cmp = 0;
  int n_err = 0;

  dir_t exp_seq [4];

  direction_controller #(
    .DEPTH    (4),
    .TICK_DIV (4),
    .INIT_DIR (DIR_RIGHT)
  ) dut (
    .i_clk     (clk),
    .i_reset   (rst),
    .i_w       (w),
    .i_a       (a),
    .i_s       (s),
    .i_d       (d),
    .i_enable  (en),
    .o_tick    (tick),
    .o_dir     (dir),
    .o_pending (pend),
    .o_dropped (drop)
  );

  always #5 clk = ~clk;

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk(input string tag, input dir_t e_dir, input int e_pend,
                     input logic e_tick, input logic e_drop);
    check({tag, " dir"},     8'(dir),  8'(e_dir));
    check({tag, " pending"}, 8'(pend), 8'(e_pend));
    check({tag, " tick"},    8'(tick), 8'(e_tick));
    check({tag, " dropped"}, 8'(drop), 8'(e_drop));
  endtask

  // Counter is 0 on entry; tick must rise on the 4th enabled edge, then gate off.
  task automatic do_tick(input string tag, input dir_t e_dir, input int e_pend);
    en = 1'b1;
    step(3);
    check({tag, " early tick"}, 8'(tick), 8'd0);
    step();
    chk(tag, e_dir, e_pend, 1'b1, 1'b0);
    en = 1'b0;
    step();
    check({tag, " tick pulse"}, 8'(tick), 8'd0);
  endtask

  initial begin
    exp_seq = '{DIR_UP, DIR_LEFT, DIR_UP, DIR_LEFT};
    rst = 1'b1;
    {w, a, s, d} = 4'b0000;
    en = 1'b0;

    // Reset state
    step();
    chk("reset", DIR_RIGHT, 0, 1'b0, 1'b0);
    rst = 1'b0;
    step();

    // Idle stepping: tick every 4th edge, nothing else moves
    en = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      step();
      check("idle tick", 8'(tick), 8'(i % 4 == 0));
      check("idle dropped", 8'(drop), 8'd0);
    end
    chk("idle end", DIR_RIGHT, 0, 1'b1, 1'b0);
    en = 1'b0;
    step();

    // Turn up, then reversal attempt
    w = 1'b1;
    step();
    chk("press w", DIR_RIGHT, 1, 1'b0, 1'b0);
    w = 1'b0;
    do_tick("turn w", DIR_UP, 0);
    s = 1'b1;
    step();
    chk("reverse s", DIR_UP, 0, 1'b0, 1'b1);
    s = 1'b0;
    step();
    check("drop one cycle", 8'(drop), 8'd0);

    // Back to RIGHT
    d = 1'b1;
    step();
    chk("press d", DIR_UP, 1, 1'b0, 1'b0);
    d = 1'b0;
    do_tick("turn d", DIR_RIGHT, 0);

    // Fill queue w,a,w,a then overflow with s
    w = 1'b1; step(); check("fill 1", 8'(pend), 8'd1);
    w = 1'b0; a = 1'b1; step(); check("fill 2", 8'(pend), 8'd2);
    a = 1'b0; w = 1'b1; step(); check("fill 3", 8'(pend), 8'd3);
    w = 1'b0; a = 1'b1; step(); chk("fill 4", DIR_RIGHT, 4, 1'b0, 1'b0);
    a = 1'b0; s = 1'b1; step(); chk("full s", DIR_RIGHT, 4, 1'b0, 1'b1);
    s = 1'b0;

    // Drain over four ticks
    en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      step();
      if (i % 4 == 3) chk("drain", exp_seq[i / 4], 3 - i / 4, 1'b1, 1'b0);
      else            check("drain no tick", 8'(tick), 8'd0);
    end
    en = 1'b0;
    step();

    // w and d together from LEFT: only w queued, d not even dropped
    w = 1'b1; d = 1'b1;
    step();
    chk("w+d", DIR_LEFT, 1, 1'b0, 1'b0);
    w = 1'b0; d = 1'b0;
    do_tick("w+d tick", DIR_UP, 0);

    // Back to RIGHT, then repeated d is ignored
    d = 1'b1;
    step();
    check("to right push", 8'(pend), 8'd1);
    d = 1'b0;
    do_tick("to right", DIR_RIGHT, 0);
    for (int i = 0; i < 2; i++) begin
      d = 1'b1;
      step();
      chk("repeat d", DIR_RIGHT, 0, 1'b0, 1'b0);
      d = 1'b0;
      step();
    end

    // w held through reset must be released and re-pressed
    w = 1'b1; rst = 1'b1;
    step();
    chk("reset w held", DIR_RIGHT, 0, 1'b0, 1'b0);
    rst = 1'b0;
    step();
    check("held w after reset", 8'(pend), 8'd0);
    step();
    check("held w still", 8'(pend), 8'd0);
    w = 1'b0;
    step();
    w = 1'b1;
    step();
    chk("w re-press", DIR_RIGHT, 1, 1'b0, 1'b0);
    w = 1'b0;

    // Full queue with a legal press landing on the pop edge
    a = 1'b1; step(); check("refill 2", 8'(pend), 8'd2);
    a = 1'b0; w = 1'b1; step(); check("refill 3", 8'(pend), 8'd3);
    w = 1'b0; a = 1'b1; step(); check("refill 4", 8'(pend), 8'd4);
    a = 1'b0;
    en = 1'b1;
    step(3);
    check("full+pop early tick", 8'(tick), 8'd0);
    s = 1'b1;
    step();
    chk("full+pop", DIR_UP, 4, 1'b1, 1'b0);
    s = 1'b0;
    en = 1'b0;
    step();

    // Gating mid-count restarts the step period
    en = 1'b1;
    step(2);
    check("gate pre", 8'(tick), 8'd0);
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("gated tick", 8'(tick), 8'd0);
    end
    en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("regate early", 8'(tick), 8'd0);
    end
    step();
    chk("regate", DIR_LEFT, 3, 1'b1, 1'b0);

    // Reset on what would otherwise be the tick edge, with 3 pending
    step(3);
    chk("pre reset", DIR_LEFT, 3, 1'b0, 1'b0);
    rst = 1'b1;
    step();
    chk("mid reset", DIR_RIGHT, 0, 1'b0, 1'b0);
    rst = 1'b0;
    en = 1'b0;
    step();
    chk("post reset", DIR_RIGHT, 0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/direction_controller.md
# direction_controller

Parametrised input front-end for the snake game core. It turns raw w/a/s/d key levels into a queue of validated turn requests and releases one direction per game step on a programmable step tick. It sits between the keypad pins and `main`, replacing direct key sampling. Game logic then sees exactly one legal direction change per move, with no lost or illegal turns.

## Interface
- `DEPTH`, 4: pending-turn queue depth; power of two, ≥2.
- `TICK_DIV`, 8: clk cycles per game step; ≥2.
- `INIT_DIR`, 2'd3 (RIGHT): direction after reset.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `w`, `a`, `s`, `d` in 1 each: raw key levels, already synchronised to `clk`.
- `enable` in 1: game running; gates the step counter.
- `tick` out 1: one-cycle step strobe.
- `dir` out 2: current direction; UP=0, LEFT=1, DOWN=2, RIGHT=3.
- `pending` out $clog2(DEPTH+1): queued turns.
- `dropped` out 1: one-cycle pulse when a press is rejected.

## Operation
- **Encoding:** opposite(x) = x ^ 2'b10.
- **Press detection:** `key_q` holds the previous key levels. A press is `key & ~key_q`, evaluated per key.
- **Simultaneous presses:** priority w > a > s > d; lower-priority presses in the same cycle are discarded silently.
- **Held keys:** a held key never repeats.
- **Reference direction `ref`:** the queue tail if `pending` > 0, else `dir`.
- **Candidate equal to `ref`:** ignored; no `dropped`.
- **Candidate equal to opposite(`ref`):** rejected; `dropped` = 1.
- **Queue full:** candidate rejected with `dropped` = 1, unless a pop happens on the same edge, in which case it is accepted and `pending` is unchanged.
- **Otherwise:** candidate pushed.
- **Step counter:** `cnt` runs 0..TICK_DIV-1 while `enable` = 1, then wraps to 0. On the wrap edge: `tick` ← 1, and if `pending` > 0, `dir` ← head and head is popped.
- **enable = 0:** `cnt` ← 0 and `tick` ← 0; the queue still accepts presses.
- **Push and pop on the same edge:**
  - Both take effect.
  - A push into an empty queue is not popped on that edge; it lands on the next tick.
  - `ref` uses pre-edge state.
- **Reset (any time, including mid-queue):**
  - Outputs: `dir` = INIT_DIR, `pending` = 0, `tick` = 0, `dropped` = 0.
  - Internal state: `cnt` = 0, `key_q` = 4'b1111.
  - Because `key_q` resets to all ones, a key held through reset must be released and pressed again before it registers.

## Timing
- Press latency: a key rising before edge k is pushed at edge k. `pending` and `dropped` are valid after edge k.
- Step period: exactly TICK_DIV cycles. The first `tick` comes TICK_DIV edges after the first edge that samples `enable` = 1 with `cnt` = 0.
- `dir` changes only on the edge that raises `tick`, so the new `dir` is valid in the same cycle that `tick` is high.
- All outputs are registered; there is no combinational path from the key inputs to any output.

## Structure
- Package `snake_pkg`:
  - `dir_t` (2-bit) and constants DIR_UP/LEFT/DOWN/RIGHT.
  - Function `opposite()`.
  - Shared with `main` and the board/body logic.
- Sub-module `dir_fifo`: synchronous FIFO, DEPTH × `dir_t`.
  - Supports simultaneous push/pop, including push-when-full-with-pop.
  - Exposes `tail`, `head`, `count`.
- Top level: edge detection, legality check, step counter.

## Test plan
All cases use DEPTH=4, TICK_DIV=4, INIT_DIR=RIGHT.
- **Idle stepping:** reset, then `enable`=1 with no keys → `tick` high every 4th cycle; `dir` = 3; `pending` = 0; `dropped` never pulses.
- **Turn and reversal:**
  - Press w → `pending` = 1 next cycle; next `tick` → `dir` = 0, `pending` = 0.
  - Press s with `dir` = 0 and queue empty → `dropped` pulses for 1 cycle; `pending` stays 0.
- **Queue fill and drain:**
  - From `dir` = 3, press w, a, w, a on separate cycles → `pending` = 4.
  - Press s → `dropped` = 1 (full).
  - Four ticks → `dir` sequence 0, 1, 0, 1; `pending` returns to 0.
- **Same-cycle keys and held keys:**
  - w and d rise in the same cycle → only w is queued.
  - Repeated d with `dir` = 3 → ignored; no `dropped`.
  - w held through reset release → no push until w falls and rises again.
- **Full with simultaneous pop:** queue full and a press (legal versus the tail) arrives on the tick edge → accepted; `pending` stays 4; `dir` takes the old head.
- **Gating and mid-run reset:**
  - `enable` = 0 mid-count → no `tick`; on re-enable the first `tick` comes 4 edges later.
  - `reset` with `pending` = 3 → next cycle `pending` = 0, `dir` = 3, `tick` = 0.
